md_sched: RTL and testbench

- Sequencer and interlock controller for the shared multiply/divide resource and its HI/LO registers.
- Accepts one mult/div/mthi/mtlo op per cycle from stage EX.
- Holds the resource busy for a fixed latency, then commits the results to architectural HI/LO.
- Generates the stall request that freezes stage ID while an instruction there (mulEnable_D) needs the resource.

---
 rtl/md_sched_pkg.sv | 28 ++
 rtl/md_sched_if.sv | 28 ++
 rtl/md_sched_arith.sv | 72 +++++++
 rtl/md_sched.sv | 141 ++++++++++++++
 tb/tb_md_sched.sv | 257 +++++++++++++++++++++++++
 5 files changed

// File: rtl/md_sched_pkg.sv
// md_pkg: shared definitions for the multiply/divide scheduler.
//   - op encodings driven on op_E by the EX stage
//   - FSM state encoding used by md_sched
//   - is_muldiv(): true for ops that occupy the resource (MULT/MULTU/DIV/DIVU)
package md_pkg;

  typedef enum logic [2:0] {
    MD_MULT  = 3'd0,
    MD_MULTU = 3'd1,
    MD_DIV   = 3'd2,
    MD_DIVU  = 3'd3,
    MD_MTHI  = 3'd4,
    MD_MTLO  = 3'd5
  } md_op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } md_state_e;

  // Latencies are limited to 1..31, so a 5-bit down-counter suffices.
  localparam int unsigned CNT_W = 5;

  function automatic logic is_muldiv(input logic [2:0] op);
    return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/md_sched_if.sv
// md_sched_if: EX-side request bus and ID-side interlock/result signals of the
// multiply/divide scheduler.
//   master (pipeline side): drives start_E, op_E, A_E, B_E, mulEnable_D, cancel;
//                           receives stall_md, busy, done, HI, LO
//   slave  (md_sched)     : the mirror image
interface md_sched_if;
  logic        start_E;
  logic [2:0]  op_E;
  logic [31:0] A_E;
  logic [31:0] B_E;
  logic        mulEnable_D;
  logic        cancel;
  logic        stall_md;
  logic        busy;
  logic        done;
  logic [31:0] HI;
  logic [31:0] LO;

  modport master (
    output start_E, op_E, A_E, B_E, mulEnable_D, cancel,
    input  stall_md, busy, done, HI, LO
  );

  modport slave (
    input  start_E, op_E, A_E, B_E, mulEnable_D, cancel,
    output stall_md, busy, done, HI, LO
  );
endinterface

// File: rtl/md_sched_arith.sv
// md_arith: purely combinational multiply/divide datapath.
//   op_i        : md_pkg op code
//   a_i, b_i    : rs / rt operands
//   hi_o, lo_o  : product {hi,lo}, or remainder (hi) / quotient (lo)
// Divide by zero yields hi=a, lo=all ones for both signed and unsigned.
// Signed ops work on magnitudes and re-apply the sign, which makes
// 0x8000_0000 / -1 come out as lo=0x8000_0000, hi=0 without a special case.
module md_arith
  import md_pkg::*;
(
  input  logic [2:0]  op_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o
);

  logic        signed_op;
  logic        a_neg;
  logic        b_neg;
  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic [31:0] b_div;
  logic [63:0] prod_mag;
  logic [63:0] prod;
  logic [31:0] q_mag;
  logic [31:0] r_mag;
  logic [31:0] quot;
  logic [31:0] rem;

  always_comb begin
    signed_op = (op_i == MD_MULT) || (op_i == MD_DIV);
    a_neg     = signed_op & a_i[31];
    b_neg     = signed_op & b_i[31];
    a_mag     = a_neg ? (~a_i + 32'd1) : a_i;
    b_mag     = b_neg ? (~b_i + 32'd1) : b_i;

    prod_mag  = {32'd0, a_mag} * {32'd0, b_mag};
    prod      = (a_neg ^ b_neg) ? (~prod_mag + 64'd1) : prod_mag;

    // Keep the divider operand non-zero so simulation never sees x/0;
    // the zero-divisor result is substituted below anyway.
    b_div     = (b_i == 32'd0) ? 32'd1 : b_mag;
    q_mag     = a_mag / b_div;
    r_mag     = a_mag % b_div;
    quot      = (a_neg ^ b_neg) ? (~q_mag + 32'd1) : q_mag;
    rem       = a_neg ? (~r_mag + 32'd1) : r_mag;

    hi_o = 32'd0;
    lo_o = 32'd0;
    case (op_i)
      MD_MULT, MD_MULTU: begin
        hi_o = prod[63:32];
        lo_o = prod[31:0];
      end
      MD_DIV, MD_DIVU: begin
        if (b_i == 32'd0) begin
          hi_o = a_i;
          lo_o = 32'hFFFF_FFFF;
        end else begin
          hi_o = rem;
          lo_o = quot;
        end
      end
      default: begin
        hi_o = 32'd0;
        lo_o = 32'd0;
      end
    endcase
  end

endmodule

// File: rtl/md_sched.sv
// md_sched: sequencer and interlock for the shared multiply/divide unit.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : md_sched_if.slave
//                start_E/op_E/A_E/B_E  - op offered by EX
//                mulEnable_D           - ID instruction needs the unit or HI/LO
//                cancel                - abort in-flight op (MD_CANCEL_EN builds)
//                stall_md              - freeze ID (combinational)
//                busy/done             - op in flight / one-cycle commit pulse
//                HI/LO                 - architectural registers
// Build option: define MD_CANCEL_EN to honour cancel; otherwise it is ignored.
// MUL_LAT / DIV_LAT must lie in 1..31.
//
// state   | meaning
// --------+-------------------------------------------------------------
// ST_IDLE | unit free; accepts mult/div/mthi/mtlo from EX
// ST_BUSY | result held in pending, counting down to commit at cnt==0
module md_sched
  import md_pkg::*;
#(
  parameter int unsigned MUL_LAT = 5,
  parameter int unsigned DIV_LAT = 10
) (
  input  logic       clk,
  input  logic       rst_n,
  md_sched_if.slave  bus
);

  localparam logic [CNT_W-1:0] MUL_CNT = 5'(MUL_LAT - 1);
  localparam logic [CNT_W-1:0] DIV_CNT = 5'(DIV_LAT - 1);

  md_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      pend_hi_q, pend_hi_d;
  logic [31:0]      pend_lo_q, pend_lo_d;
  logic [31:0]      hi_q, hi_d;
  logic [31:0]      lo_q, lo_d;
  logic             done_q, done_d;
  logic [31:0]      arith_hi;
  logic [31:0]      arith_lo;
  logic             cancel_w;

`ifdef MD_CANCEL_EN
  assign cancel_w = bus.cancel;
`else
  logic unused_cancel;
  assign unused_cancel = bus.cancel;
  assign cancel_w      = 1'b0;
`endif

  md_arith u_arith (
    .op_i (bus.op_E),
    .a_i  (bus.A_E),
    .b_i  (bus.B_E),
    .hi_o (arith_hi),
    .lo_o (arith_lo)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pend_hi_d = pend_hi_q;
    pend_lo_d = pend_lo_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // cancel has no meaning here; a start on the same edge always wins.
        if (bus.start_E) begin
          case (bus.op_E)
            MD_MULT, MD_MULTU: begin
              pend_hi_d = arith_hi;
              pend_lo_d = arith_lo;
              cnt_d     = MUL_CNT;
              state_d   = ST_BUSY;
            end
            MD_DIV, MD_DIVU: begin
              pend_hi_d = arith_hi;
              pend_lo_d = arith_lo;
              cnt_d     = DIV_CNT;
              state_d   = ST_BUSY;
            end
            MD_MTHI: hi_d = bus.A_E;
            MD_MTLO: lo_d = bus.A_E;
            default: ;
          endcase
        end
      end
      ST_BUSY: begin
        // A start here is a protocol violation and is simply ignored.
        if (cancel_w) begin
          pend_hi_d = 32'd0;
          pend_lo_d = 32'd0;
          cnt_d     = '0;
          state_d   = ST_IDLE;
        end else if (cnt_q == '0) begin
          hi_d    = pend_hi_q;
          lo_d    = pend_lo_q;
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - 5'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      pend_hi_q <= 32'd0;
      pend_lo_q <= 32'd0;
      hi_q      <= 32'd0;
      lo_q      <= 32'd0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pend_hi_q <= pend_hi_d;
      pend_lo_q <= pend_lo_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      done_q    <= done_d;
    end
  end

  assign bus.busy     = (state_q == ST_BUSY);
  assign bus.done     = done_q;
  assign bus.HI       = hi_q;
  assign bus.LO       = lo_q;
  // Stall already in the start cycle so the ID consumer never races the accept.
  assign bus.stall_md = bus.mulEnable_D &
                        ((state_q == ST_BUSY) | (bus.start_E & is_muldiv(bus.op_E)));

  md_start_busy: assert property (@(posedge clk) disable iff (!rst_n)
                                  !(bus.start_E && (state_q == ST_BUSY)));

endmodule

// File: tb/tb_md_sched.sv
module tb_md_sched;
  import md_pkg::*;

  localparam int MUL_LAT = 5;
  localparam int DIV_LAT = 10;
`ifdef MD_CANCEL_EN
  localparam bit CANCEL_EN = 1'b1;
`else
  localparam bit CANCEL_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  md_sched_if bus ();

  md_sched #(.MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int failures = 0;

  // Behavioural model: remaining busy cycles plus result registers.
  int          m_left;
  logic [31:0] m_hi, m_lo, m_phi, m_plo;
  bit          m_done;

  function automatic logic [63:0] ref_result(logic [2:0] op, logic [31:0] a, logic [31:0] b);
    longint          sa, sb, sq, sr;
    longint unsigned ua, ub, uq, ur;
    logic [63:0]     res;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = 64'(a);
    ub = 64'(b);
    res = 64'd0;
    case (op)
      3'd0: res = 64'(sa * sb);
      3'd1: res = ua * ub;
      3'd2: begin
        if (b == 32'd0) res = {a, 32'hFFFF_FFFF};
        else begin
          sq = sa / sb;
          sr = sa % sb;
          res = {sr[31:0], sq[31:0]};
        end
      end
      3'd3: begin
        if (b == 32'd0) res = {a, 32'hFFFF_FFFF};
        else begin
          uq = ua / ub;
          ur = ua % ub;
          res = {ur[31:0], uq[31:0]};
        end
      end
      default: res = 64'd0;
    endcase
    return res;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_left = 0; m_hi = 0; m_lo = 0; m_phi = 0; m_plo = 0; m_done = 0;
  endtask

  task automatic model_edge();
    logic [63:0] r;
    m_done = 0;
    if (m_left > 0) begin
      if (CANCEL_EN && bus.cancel) m_left = 0;
      else begin
        m_left--;
        if (m_left == 0) begin
          m_hi = m_phi; m_lo = m_plo; m_done = 1;
        end
      end
    end else if (bus.start_E) begin
      r = ref_result(bus.op_E, bus.A_E, bus.B_E);
      if (bus.op_E < 3'd2) begin m_left = MUL_LAT; m_phi = r[63:32]; m_plo = r[31:0]; end
      else if (bus.op_E < 3'd4) begin m_left = DIV_LAT; m_phi = r[63:32]; m_plo = r[31:0]; end
      else if (bus.op_E == 3'd4) m_hi = bus.A_E;
      else if (bus.op_E == 3'd5) m_lo = bus.A_E;
    end
  endtask

  task automatic compare_state();
    chk("busy", bus.busy, (m_left > 0));
    chk("done", bus.done, m_done);
    chk("HI", bus.HI, m_hi);
    chk("LO", bus.LO, m_lo);
  endtask

  // Inputs are set at a negedge; this checks stall, advances one edge,
  // and compares registered outputs at the following negedge.
  task automatic cycle();
    bit exp_stall;
    #1;
    exp_stall = bus.mulEnable_D && ((m_left > 0) || (bus.start_E && bus.op_E < 3'd4));
    chk("stall_md", bus.stall_md, exp_stall);
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare_state();
  endtask

  task automatic idle_inputs();
    bus.start_E = 0; bus.op_E = 0; bus.A_E = 0; bus.B_E = 0;
    bus.mulEnable_D = 0; bus.cancel = 0;
  endtask

  task automatic run_op(input string name, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input bit men, input int lat,
                        input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                        input bit hold_zero);
    int nb;
    int n;
    bus.start_E = 1; bus.op_E = op; bus.A_E = a; bus.B_E = b; bus.mulEnable_D = men;
    cycle();
    bus.start_E = 0;
    nb = 0; n = 0;
    while (!bus.done && n < 40) begin
      if (bus.busy) nb++;
      if (hold_zero) begin
        chk({name, "_hidden_hi"}, bus.HI, 32'd0);
        chk({name, "_hidden_lo"}, bus.LO, 32'd0);
      end
      cycle();
      n++;
    end
    chk({name, "_done_seen"}, bus.done, 1'b1);
    chk({name, "_busy_cycles"}, 64'(nb), 64'(lat));
    chk({name, "_HI"}, bus.HI, exp_hi);
    chk({name, "_LO"}, bus.LO, exp_lo);
    bus.mulEnable_D = 0;
  endtask

  function automatic logic [31:0] pick();
    case ($urandom % 6)
      0: return 32'd0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'($urandom % 16);
      default: return 32'($urandom);
    endcase
  endfunction

  initial begin
    int dones;
    idle_inputs();
    model_reset();
    #1;
    chk("rst_busy", bus.busy, 1'b0);
    chk("rst_done", bus.done, 1'b0);
    chk("rst_HI", bus.HI, 32'd0);
    chk("rst_LO", bus.LO, 32'd0);
    chk("rst_stall", bus.stall_md, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1;

    // Start-cycle stall with mulEnable_D set.
    bus.start_E = 1; bus.op_E = MD_MULT; bus.A_E = 32'hFFFF_FFFD; bus.B_E = 32'd7;
    bus.mulEnable_D = 1;
    #1 chk("stall_start_cycle", bus.stall_md, 1'b1);
    run_op("mult_m3x7", MD_MULT, 32'hFFFF_FFFD, 32'd7, 1, MUL_LAT,
           32'hFFFF_FFFF, 32'hFFFF_FFEB, 1);
    run_op("multu_nostall", MD_MULTU, 32'hFFFF_FFFF, 32'd2, 0, MUL_LAT,
           32'd1, 32'hFFFF_FFFE, 0);
    run_op("divu_100_7", MD_DIVU, 32'd100, 32'd7, 0, DIV_LAT, 32'd2, 32'd14, 0);
    run_op("div_m7_2", MD_DIV, 32'hFFFF_FFF9, 32'd2, 1, DIV_LAT,
           32'hFFFF_FFFF, 32'hFFFF_FFFD, 0);
    run_op("div_ovf", MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 0, DIV_LAT,
           32'd0, 32'h8000_0000, 0);
    run_op("divu_by0", MD_DIVU, 32'd5, 32'd0, 0, DIV_LAT, 32'd5, 32'hFFFF_FFFF, 0);
    run_op("div_by0", MD_DIV, 32'hFFFF_FFF0, 32'd0, 0, DIV_LAT,
           32'hFFFF_FFF0, 32'hFFFF_FFFF, 0);

    // MTLO while idle: visible next cycle, no busy, no stall.
    bus.start_E = 1; bus.op_E = MD_MTLO; bus.A_E = 32'h1234; bus.mulEnable_D = 1;
    #1 chk("mtlo_stall", bus.stall_md, 1'b0);
    cycle();
    bus.start_E = 0; bus.mulEnable_D = 0;
    chk("mtlo_LO", bus.LO, 32'h1234);
    chk("mtlo_busy", bus.busy, 1'b0);
    chk("mtlo_done", bus.done, 1'b0);

    // Cancel scenario: preset HI=1, LO=2, MULT 6*7, cancel in busy cycle 3.
    bus.start_E = 1; bus.op_E = MD_MTHI; bus.A_E = 32'd1; cycle();
    bus.op_E = MD_MTLO; bus.A_E = 32'd2; cycle();
    bus.op_E = MD_MULT; bus.A_E = 32'd6; bus.B_E = 32'd7; cycle();
    bus.start_E = 0;
    cycle();
    cycle();
    bus.cancel = 1;
    cycle();
    bus.cancel = 0;
    dones = 0;
    for (int i = 0; i < 8; i++) begin
      if (bus.done) dones++;
      cycle();
    end
`ifdef MD_CANCEL_EN
    chk("cancel_dones", 64'(dones), 64'd0);
    chk("cancel_HI", bus.HI, 32'd1);
    chk("cancel_LO", bus.LO, 32'd2);
`else
    chk("nocancel_dones", 64'(dones), 64'd1);
    chk("nocancel_HI", bus.HI, 32'd0);
    chk("nocancel_LO", bus.LO, 32'd42);
`endif

    // Async reset in busy cycle 4 of a divide.
    bus.start_E = 1; bus.op_E = MD_DIVU; bus.A_E = 32'd1000; bus.B_E = 32'd3; cycle();
    bus.start_E = 0;
    cycle(); cycle(); cycle();
    rst_n = 0;
    #1;
    model_reset();
    chk("arst_busy", bus.busy, 1'b0);
    chk("arst_HI", bus.HI, 32'd0);
    chk("arst_LO", bus.LO, 32'd0);
    @(negedge clk);
    rst_n = 1;
    dones = 0;
    for (int i = 0; i < 20; i++) begin
      cycle();
      if (bus.done) dones++;
    end
    chk("arst_no_done", 64'(dones), 64'd0);

    // Randomized traffic, protocol-legal starts only.
    for (int i = 0; i < 1500; i++) begin
      bus.op_E = 3'($urandom % 6);
      bus.A_E = pick();
      bus.B_E = pick();
      bus.mulEnable_D = $urandom % 2;
      bus.cancel = (($urandom % 8) == 0);
      bus.start_E = (m_left == 0) && (($urandom % 3) == 0);
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
